// File: rtl/aes_v2_mix_arb_pkg.sv
// Shared types, constants and GF(2^8) helper for the byte-serial MixColumns arbiter.
// The build macro AES_V2_MIX_ARB_RR_EN (used by the top) selects round-robin over fixed priority.
package aes_v2_mix_pkg;

  localparam logic [1:0] MIX_IDLE = 2'd0;
  localparam logic [1:0] MIX_BUSY = 2'd1;
  localparam logic [1:0] MIX_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MIX_IDLE,
    ST_BUSY = MIX_BUSY,
    ST_RESP = MIX_RESP
  } mix_state_t;

  localparam int MIX_STEPS = 4;

  localparam logic [7:0] MIX_GF_POLY = 8'h1b;

  // Index 0 multiplies a_s, index 3 multiplies a_(s+3).
  localparam logic [3:0][7:0] MIX_FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam logic [3:0][7:0] MIX_INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? MIX_GF_POLY : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_v2_mix_arb_if.sv
// Request/response bundle between two issue sources and the MixColumns arbiter.
interface aes_v2_mix_arb_if;
  // Both channels: a transfer happens on a rising edge where valid && ready; the
  // sender holds valid and payload stable until then, and ready may depend on valid.
  logic        req0_valid;
  logic [31:0] req0_rs1;
  logic [31:0] req0_rs2;
  logic        req0_enc;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_rd;
  logic        rsp0_ready;

  logic        req1_valid;
  logic [31:0] req1_rs1;
  logic [31:0] req1_rs2;
  logic        req1_enc;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_rd;
  logic        rsp1_ready;

  logic [1:0]  dbg_state;

  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_enc, rsp0_ready,
    output req1_valid, req1_rs1, req1_rs2, req1_enc, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_rd,
    input  req1_ready, rsp1_valid, rsp1_rd,
    input  dbg_state
  );

  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_enc, rsp0_ready,
    input  req1_valid, req1_rs1, req1_rs2, req1_enc, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_rd,
    output req1_ready, rsp1_valid, rsp1_rd,
    output dbg_state
  );
endinterface

// File: rtl/aes_v2_mix_arb_step.sv
// One MixColumns output byte from the rotated column a_s..a_(s+3).
module aes_v2_mix_step
  import aes_v2_mix_pkg::*;
(
  input  logic [3:0][7:0] i_rot,
  input  logic            i_enc,
  output logic [7:0]      o_b
);

  logic [3:0][7:0] w_coef;

  assign w_coef = i_enc ? MIX_FWD_COEF : MIX_INV_COEF;

  assign o_b = gf_mul(i_rot[0], w_coef[0]) ^ gf_mul(i_rot[1], w_coef[1]) ^
               gf_mul(i_rot[2], w_coef[2]) ^ gf_mul(i_rot[3], w_coef[3]);

endmodule

// File: rtl/aes_v2_mix_arb.sv
// Two-port arbiter/sequencer for a byte-serial MixColumns engine (IDLE -> BUSY x4 -> RESP).
// Define AES_V2_MIX_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module aes_v2_mix_arb
  import aes_v2_mix_pkg::*;
(
  input  logic             g_clk,
  input  logic             g_resetn,
  aes_v2_mix_arb_if.slave  bus
);

  mix_state_t      r_state;
  logic [1:0]      r_step;
  logic [3:0][7:0] r_op;
  logic [3:0][7:0] r_result;
  logic            r_enc;
  logic            r_grant;
`ifdef AES_V2_MIX_ARB_RR_EN
  logic            r_last;
`endif

  logic            w_pick;
  logic            w_accept;
  logic [31:0]     w_rs1;
  logic [31:0]     w_rs2;
  logic            w_enc;
  logic [3:0][7:0] w_rot;
  logic [7:0]      w_byte;
  logic            w_rsp_ready;

  // w_pick is the winning port id; it only matters when some request is valid.
`ifdef AES_V2_MIX_ARB_RR_EN
  assign w_pick = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
`else
  assign w_pick = ~bus.req0_valid;
`endif

  assign w_accept = g_resetn && (r_state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = w_accept && !w_pick;
  assign bus.req1_ready = w_accept &&  w_pick;

  assign w_rs1 = w_pick ? bus.req1_rs1 : bus.req0_rs1;
  assign w_rs2 = w_pick ? bus.req1_rs2 : bus.req0_rs2;
  assign w_enc = w_pick ? bus.req1_enc : bus.req0_enc;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < MIX_STEPS; i++) begin
      w_rot[i] = r_op[r_step + 2'(i)];
    end
  end

  aes_v2_mix_step u_step (
    .i_rot (w_rot),
    .i_enc (r_enc),
    .o_b   (w_byte)
  );

  assign w_rsp_ready = r_grant ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state  <= ST_IDLE;
      r_step   <= 2'd0;
      r_op     <= '0;
      r_result <= '0;
      r_enc    <= 1'b0;
      r_grant  <= 1'b0;
`ifdef AES_V2_MIX_ARB_RR_EN
      r_last   <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= {w_rs2[31:24], w_rs2[23:16], w_rs1[15:8], w_rs1[7:0]};
            r_enc   <= w_enc;
            r_grant <= w_pick;
            r_step  <= 2'd0;
`ifdef AES_V2_MIX_ARB_RR_EN
            r_last  <= w_pick;
`endif
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_result[r_step] <= w_byte;
          r_step           <= r_step + 2'd1;
          if (r_step == 2'(MIX_STEPS - 1)) r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp0_valid = (r_state == ST_RESP) && !r_grant;
  assign bus.rsp1_valid = (r_state == ST_RESP) &&  r_grant;
  assign bus.rsp0_rd    = bus.rsp0_valid ? r_result : 32'h0;
  assign bus.rsp1_rd    = bus.rsp1_valid ? r_result : 32'h0;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_aes_v2_mix_arb.sv
// Directed bench for aes_v2_mix_arb: known MixColumns vectors, latency, arbitration,
// backpressure and asynchronous reset in the middle of an operation.
module tb_aes_v2_mix_arb;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  aes_v2_mix_arb_if bus();

  aes_v2_mix_arb dut (
    .g_clk    (clk),
    .g_resetn (rst_n),
    .bus      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_rs1 = '0; bus.req0_rs2 = '0; bus.req0_enc = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_rs1 = '0; bus.req1_rs2 = '0; bus.req1_enc = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver tasks
  task automatic drive_req(input int p, input logic [31:0] col, input logic enc, input logic vld);
    if (p == 0) begin
      bus.req0_rs1 = {16'h0, col[15:0]}; bus.req0_rs2 = {col[31:16], 16'h0};
      bus.req0_enc = enc; bus.req0_valid = vld;
    end else begin
      bus.req1_rs1 = {16'h0, col[15:0]}; bus.req1_rs2 = {col[31:16], 16'h0};
      bus.req1_enc = enc; bus.req1_valid = vld;
    end
  endtask

  // Issue one op, return its result word, accept-to-valid latency and a timeout flag.
  task automatic run_op(input int p, input logic [31:0] col, input logic enc,
                        output logic [31:0] rd, output int lat, output bit ok);
    int w;
    ok = 1'b1;
    @(negedge clk);
    drive_req(p, col, enc, 1'b1);
    #1;
    w = 0;
    while (!(p == 0 ? bus.req0_ready : bus.req1_ready) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 20) ok = 1'b0;
    @(posedge clk); #1;
    drive_req(p, col, enc, 1'b0);
    lat = 0;
    while (!(p == 0 ? bus.rsp0_valid : bus.rsp1_valid) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 20) ok = 1'b0;
    rd = (p == 0) ? bus.rsp0_rd : bus.rsp1_rd;
    if (p == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000",
        {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
    end
    checks++;
    if (bus.rsp0_rd !== 32'h0 || bus.rsp1_rd !== 32'h0) begin
      errors++; $display("FAIL reset_rd: got %h/%h want 0/0", bus.rsp0_rd, bus.rsp1_rd);
    end
    checks++;
    if (bus.dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL idle_no_req_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
    end
  endtask

  task automatic test_forward();
    logic [31:0] rd; int lat; bit ok;
    run_op(0, 32'h4553_13db, 1'b1, rd, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fwd_timeout: got timeout want completion"); end
    checks++;
    if (rd !== 32'hbca14d8e) begin errors++; $display("FAIL fwd_rd: got %h want bca14d8e", rd); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL fwd_latency: got %0d want 4", lat); end
    checks++;
    if (bus.rsp1_valid !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL fwd_rsp_after: got %b%b want 00", bus.rsp1_valid, bus.rsp0_valid);
    end
  endtask

  task automatic test_inverse();
    logic [31:0] rd; int lat; bit ok;
    run_op(1, 32'hbca1_4d8e, 1'b0, rd, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL inv_timeout: got timeout want completion"); end
    checks++;
    if (rd !== 32'h455313db) begin errors++; $display("FAIL inv_rd: got %h want 455313db", rd); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL inv_latency: got %0d want 4", lat); end
  endtask

  task automatic test_vectors();
    logic [31:0] rd; int lat; bit ok;
    run_op(0, 32'hc6c6c6c6, 1'b1, rd, lat, ok);
    checks++;
    if (!ok || rd !== 32'hc6c6c6c6) begin
      errors++; $display("FAIL vec_fixed_point: got %h ok=%0d want c6c6c6c6", rd, ok);
    end
    run_op(0, 32'h5c220af2, 1'b1, rd, lat, ok);
    checks++;
    if (!ok || rd !== 32'h9d58dc9f) begin
      errors++; $display("FAIL vec_second: got %h ok=%0d want 9d58dc9f", rd, ok);
    end
    run_op(1, 32'h9d58dc9f, 1'b0, rd, lat, ok);
    checks++;
    if (!ok || rd !== 32'h5c220af2) begin
      errors++; $display("FAIL vec_second_inv: got %h ok=%0d want 5c220af2", rd, ok);
    end
  endtask

  task automatic test_backpressure();
    int w;
    @(negedge clk);
    drive_req(0, 32'h5c220af2, 1'b1, 1'b1);
    #1;
    w = 0;
    while (!bus.req0_ready && w < 20) begin @(negedge clk); #1; w++; end
    @(posedge clk); #1;
    drive_req(0, 32'h5c220af2, 1'b1, 1'b0);
    drive_req(1, 32'hbca1_4d8e, 1'b0, 1'b1);
    w = 0;
    while (!bus.rsp0_valid && w < 20) begin @(posedge clk); #1; w++; end
    checks++;
    if (w !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", w); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rd !== 32'h9d58dc9f || bus.req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b rd=%h r1=%b want v=1 rd=9d58dc9f r1=0",
          i, bus.rsp0_valid, bus.rsp0_rd, bus.req1_ready);
      end
    end
    bus.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp0_rd !== 32'h0 || bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after_hs: got v=%b rd=%h r1=%b want v=0 rd=0 r1=1",
        bus.rsp0_valid, bus.rsp0_rd, bus.req1_ready);
    end
    @(posedge clk); #1;
    drive_req(1, 32'hbca1_4d8e, 1'b0, 1'b0);
    w = 0;
    while (!bus.rsp1_valid && w < 20) begin @(posedge clk); #1; w++; end
    checks++;
    if (w !== 4 || bus.rsp1_rd !== 32'h455313db) begin
      errors++; $display("FAIL bp_req1_op: got lat=%0d rd=%h want lat=4 rd=455313db", w, bus.rsp1_rd);
    end
    bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_arb();
    int grants[$];
    int exp_g[4];
    int cyc;
`ifdef AES_V2_MIX_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    do_reset();
    drive_req(0, 32'hc6c6c6c6, 1'b1, 1'b1);
    drive_req(1, 32'h4553_13db, 1'b1, 1'b1);
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    cyc = 0;
    while (grants.size() < 4 && cyc < 100) begin
      @(negedge clk);
      if (bus.req0_valid && bus.req0_ready) grants.push_back(0);
      if (bus.req1_valid && bus.req1_ready) grants.push_back(1);
      cyc++;
    end
    @(posedge clk); #1;
    drive_req(0, 32'h0, 1'b0, 1'b0);
    drive_req(1, 32'h0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grants.size()) begin
        errors++; $display("FAIL arb_grant[%0d]: got none want %0d", i, exp_g[i]);
      end else if (grants[i] !== exp_g[i]) begin
        errors++; $display("FAIL arb_grant[%0d]: got %0d want %0d", i, grants[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; bit ok; int w;
    @(negedge clk);
    drive_req(0, 32'hc6c6c6c6, 1'b1, 1'b1);
    #1;
    w = 0;
    while (!bus.req0_ready && w < 20) begin @(negedge clk); #1; w++; end
    @(posedge clk); #1;
    drive_req(0, 32'hc6c6c6c6, 1'b1, 1'b0);
    bus.rsp0_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (bus.dbg_state !== 2'd1) begin errors++; $display("FAIL mid_busy: got %0d want 1", bus.dbg_state); end
    drive_req(0, 32'hc6c6c6c6, 1'b1, 1'b1);
    drive_req(1, 32'hc6c6c6c6, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0000 ||
        bus.rsp0_rd !== 32'h0 || bus.rsp1_rd !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b rd=%h/%h want 0000 rd=0/0",
        {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, bus.rsp0_rd, bus.rsp1_rd);
    end
    checks++;
    if (bus.dbg_state !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d want 0", bus.dbg_state); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'h5c220af2, 1'b1, rd, lat, ok);
    checks++;
    if (!ok || rd !== 32'h9d58dc9f || lat !== 4) begin
      errors++; $display("FAIL mid_reissue: got rd=%h lat=%0d ok=%0d want rd=9d58dc9f lat=4", rd, lat, ok);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_vectors();
    test_backpressure();
    test_arb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
